// File: rtl/mem_write_checker.sv
// mem_write_checker: snoops the MIPS data-memory write port and checks it
// against a loadable, ordered table of expected (address, data) writes.
// Reports sticky pass/fail with error capture and a RUN-state cycle timeout.
// Optional feature macro: WCHK_IGNORE_EN -- writes to IGNORE_ADR that do not
// match the expected entry are skipped instead of failing the run.
module mem_write_checker #(
    parameter int                WIDTH      = 32,
    parameter int                DEPTH      = 8,
    parameter int                TIMEOUT    = 1024,
    parameter logic [WIDTH-1:0]  IGNORE_ADR = WIDTH'(80),
    localparam int               IDX_W      = $clog2(DEPTH),
    localparam int               TMR_W      = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [WIDTH-1:0] load_adr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [IDX_W:0]   num_exp,
    input  logic             start,
    input  logic             clear,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [IDX_W:0]   match_cnt,
    output logic [IDX_W-1:0] err_idx,
    output logic [WIDTH-1:0] err_adr,
    output logic [WIDTH-1:0] err_data
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    localparam logic [IDX_W:0]   NUM_MAX  = (IDX_W + 1)'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    logic [WIDTH-1:0] tbl_adr  [DEPTH];
    logic [WIDTH-1:0] tbl_data [DEPTH];
    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   num_q;
    logic [TMR_W-1:0] timer;

    logic [IDX_W:0]   num_clamped;
    logic             hit;
    logic             ign;
    logic             last;

    // Expected-table storage; writable only while idle.
    // NOTE: the table is cleared by reset, so every entry sits on the async reset
    // and the array builds as flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_adr[i]  <= '0;
                tbl_data[i] <= '0;
            end
        end else if (load_en && state == S_IDLE) begin
            tbl_adr[load_idx]  <= load_adr;
            tbl_data[load_idx] <= load_data;
        end
    end

    // Decode this cycle's snooped write against the expected entry.
    // NOTE: each flag defaults to 0 and is raised only inside an if, so an X/Z
    // on the bus reads as "no hit" (a mismatch) and no latch is inferred.
    always_comb begin
        num_clamped = (num_exp > NUM_MAX) ? NUM_MAX : num_exp;
        last        = ({1'b0, ptr} == num_q - (IDX_W + 1)'(1));
        hit         = 1'b0;
        ign         = 1'b0;
        if (memwrite && dataadr == tbl_adr[ptr] && writedata == tbl_data[ptr])
            hit = 1'b1;
`ifdef WCHK_IGNORE_EN
        if (memwrite && dataadr == IGNORE_ADR)
            ign = 1'b1;
`endif
    end

    // Checker FSM with registered status and error-capture outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            match_cnt <= '0;
            err_idx   <= '0;
            err_adr   <= '0;
            err_data  <= '0;
            ptr       <= '0;
            num_q     <= '0;
            timer     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr       <= '0;
                        timer     <= '0;
                        match_cnt <= '0;
                        num_q     <= num_clamped;
                        if (num_clamped == '0) begin
                            state <= S_PASS;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    timer <= timer + TMR_W'(1);
                    if (hit) begin
                        ptr       <= ptr + IDX_W'(1);
                        match_cnt <= match_cnt + (IDX_W + 1)'(1);
                    end
                    if (hit && last) begin
                        state <= S_PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (memwrite && !hit && !ign) begin
                        state    <= S_FAIL;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b0;
                        err_idx  <= ptr;
                        err_adr  <= dataadr;
                        err_data <= writedata;
                    end else if (timer == TMR_LAST) begin
                        state    <= S_FAIL;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        err_idx  <= ptr;
                        err_adr  <= '0;
                        err_data <= '0;
                    end
                end
                S_PASS, S_FAIL: begin
                    if (clear) begin
                        state     <= S_IDLE;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        match_cnt <= '0;
                        err_idx   <= '0;
                        err_adr   <= '0;
                        err_data  <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Testbench for mem_write_checker: directed vectors, scoreboard of expected
// final results checked by a monitor on each rising edge of done.
module tb_mem_write_checker;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int TO = 16;

    typedef struct {
        logic        p;
        logic        t;
        logic [3:0]  mc;
        logic [2:0]  ei;
        logic [31:0] ea;
        logic [31:0] ed;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        load_en = 0;
    logic [2:0]  load_idx = 0;
    logic [31:0] load_adr = 0;
    logic [31:0] load_data = 0;
    logic [3:0]  num_exp = 0;
    logic        start = 0;
    logic        clear = 0;
    logic        memwrite = 0;
    logic [31:0] dataadr = 0;
    logic [31:0] writedata = 0;
    logic        busy, done, pass, timeout;
    logic [3:0]  match_cnt;
    logic [2:0]  err_idx;
    logic [31:0] err_adr, err_data;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic done_q = 0;

    mem_write_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst),
        .load_en(load_en), .load_idx(load_idx), .load_adr(load_adr), .load_data(load_data),
        .num_exp(num_exp), .start(start), .clear(clear),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .match_cnt(match_cnt), .err_idx(err_idx), .err_adr(err_adr), .err_data(err_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p, input logic t, input logic [3:0] mc,
                        input logic [2:0] ei, input logic [31:0] ea, input logic [31:0] ed);
        exp_t e;
        e.p = p; e.t = t; e.mc = mc; e.ei = ei; e.ea = ea; e.ed = ed;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
        load_en = 1; load_idx = idx; load_adr = a; load_data = d;
        tick();
        load_en = 0;
    endtask

    task automatic do_start(input logic [3:0] n);
        num_exp = n; start = 1;
        tick();
        start = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1; dataadr = a; writedata = d;
        tick();
        memwrite = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    // Bounded wait for done, then one more edge so the monitor has sampled it.
    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", {63'd0, done}, 64'd1);
        tick();
    endtask

    // Monitor: pop the scoreboard on each new completion and compare.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done && !done_q) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL sb_unexpected: completion with empty scoreboard");
            end else begin
                e = sb.pop_front();
                check("sb_pass",      {63'd0, pass},      {63'd0, e.p});
                check("sb_timeout",   {63'd0, timeout},   {63'd0, e.t});
                check("sb_match_cnt", {60'd0, match_cnt}, {60'd0, e.mc});
                check("sb_err_idx",   {61'd0, err_idx},   {61'd0, e.ei});
                check("sb_err_adr",   {32'd0, err_adr},   {32'd0, e.ea});
                check("sb_err_data",  {32'd0, err_data},  {32'd0, e.ed});
            end
        end
        done_q = done;
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", {60'd0, busy, done, pass, timeout}, 64'd0);
        check("rst_match",  {60'd0, match_cnt}, 64'd0);
        check("rst_err",    {err_adr, err_data}, 64'd0);
        rst = 0;
        tick();

        // Single expected write at cycle 5
        do_load(0, 84, 7);
        push(1, 0, 1, 0, 0, 0);
        do_start(1);
        check("single_busy", {63'd0, busy}, 64'd1);
        repeat (4) tick();
        do_write(84, 7);
        check("single_pass", {62'd0, pass, busy}, 64'd2);
        check("single_mc",   {60'd0, match_cnt}, 64'd1);
        tick();
        do_clear();
        check("clear_zero", {59'd0, done, match_cnt}, 64'd0);

        // Mismatch capture
        do_load(1, 88, 9);
        push(0, 0, 1, 1, 88, 10);
        do_start(2);
        do_write(84, 7);
        do_write(88, 10);
        wait_done(4);
        do_clear();

        // Ignore window
`ifdef WCHK_IGNORE_EN
        push(1, 0, 1, 0, 0, 0);
`else
        push(0, 0, 0, 0, 80, 3);
`endif
        do_start(1);
        do_write(80, 3);
        do_write(84, 7);
        wait_done(4);
        do_clear();

        // Timeout: busy for exactly TO cycles
        push(0, 1, 0, 0, 0, 0);
        do_start(1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        check("timeout_busy_cycles", 64'(n), 64'(TO));
        wait_done(4);
        do_clear();

        // Final match on the last timer cycle still passes
        push(1, 0, 1, 0, 0, 0);
        do_start(1);
        repeat (TO - 1) tick();
        check("late_still_busy", {63'd0, busy}, 64'd1);
        do_write(84, 7);
        wait_done(2);
        do_clear();

        // num_exp = 0 passes one cycle after start
        push(1, 0, 0, 0, 0, 0);
        do_start(0);
        check("zero_pass", {61'd0, done, pass, busy}, 64'd6);
        tick();
        do_clear();

        // num_exp = DEPTH, last entry loaded in the same cycle as start
        for (int i = 0; i < D - 1; i++) do_load(3'(i), 32'(100 + 4 * i), 32'(3 * i + 1));
        push(1, 0, 8, 0, 0, 0);
        load_en = 1; load_idx = 7; load_adr = 128; load_data = 22;
        num_exp = 8; start = 1;
        tick();
        load_en = 0; start = 0;
        for (int i = 0; i < D; i++) do_write(32'(100 + 4 * i), 32'(3 * i + 1));
        wait_done(4);

        // Clear then re-run retained table; num_exp 15 clamps to DEPTH
        do_clear();
        push(1, 0, 8, 0, 0, 0);
        do_start(15);
        for (int i = 0; i < D; i++) do_write(32'(100 + 4 * i), 32'(3 * i + 1));
        wait_done(4);
        do_clear();

        // Reset mid-RUN after two matches
        do_start(8);
        do_write(100, 1);
        do_write(104, 4);
        check("pre_rst_mc", {59'd0, busy, match_cnt}, 64'h12);
        rst = 1;
        #1;
        check("rst_mid_status", {60'd0, busy, done, pass, timeout}, 64'd0);
        check("rst_mid_match",  {60'd0, match_cnt}, 64'd0);
        check("rst_mid_err",    {err_adr, err_data}, 64'd0);
        check("rst_mid_idx",    {61'd0, err_idx}, 64'd0);
        tick();
        rst = 0;
        tick();
        check("rst_idle", {62'd0, busy, done}, 64'd0);

        // Reset cleared the table: entry 0 is now (0, 0)
        push(1, 0, 1, 0, 0, 0);
        do_start(1);
        do_write(0, 0);
        wait_done(4);
        do_clear();

        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
